// File: rtl/hazard_pkg.sv
// Shared encodings for the forwarding/hazard unit: operand select codes and
// load-use stall FSM states.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } hz_state_e;

endpackage

// File: rtl/rs_match_cell.sv
// One source operand compared against one pipeline stage destination, with
// valid/write-enable gating and optional hard-wired x0 exclusion.
module rs_match_cell #(
    parameter int ADDR_W      = 5,
    parameter bit ZERO_REG_HW = 1'b1
) (
    input  logic              id_valid_i,
    input  logic              rs_used_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic              stg_valid_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              reg_write_i,
    output logic              hit_o
);

    logic rd_is_zero;

    assign rd_is_zero = (rd_addr_i == '0);

    assign hit_o = id_valid_i & rs_used_i & stg_valid_i & reg_write_i &
                   (rd_addr_i == rs_addr_i) & ~(ZERO_REG_HW & rd_is_zero);

endmodule

// File: rtl/forward_hazard_unit.sv
// Decode-stage hazard detector: registered per-source EX operand forwarding
// selects plus a load-use stall FSM with programmable bubble count.
import hazard_pkg::*;

module forward_hazard_unit #(
    parameter int NUM_SRC        = 2,
    parameter int ADDR_W         = 5,
    parameter int LOAD_STALL_CYC = 1,
    parameter bit ZERO_REG_HW    = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      id_valid_i,
    input  logic [NUM_SRC*ADDR_W-1:0] id_rs_addr_i,
    input  logic [NUM_SRC-1:0]        id_rs_used_i,
    input  logic                      ex_valid_i,
    input  logic [ADDR_W-1:0]         ex_rd_addr_i,
    input  logic                      ex_reg_write_i,
    input  logic                      ex_is_load_i,
    input  logic                      mem_valid_i,
    input  logic [ADDR_W-1:0]         mem_rd_addr_i,
    input  logic                      mem_reg_write_i,
    output logic [2*NUM_SRC-1:0]      fwd_sel_o,
    output logic                      stall_o,
    output logic                      bubble_o,
    output logic                      stall_active_o
);

    localparam logic [2:0] CNT_INIT = 3'(LOAD_STALL_CYC - 1);

    logic [NUM_SRC-1:0]      ex_hit, mem_hit;
    logic                    lu_hit;
    hz_state_e               state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [NUM_SRC-1:0][1:0] fwd_q, fwd_d;
    logic                    stall;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        rs_match_cell #(.ADDR_W(ADDR_W), .ZERO_REG_HW(ZERO_REG_HW)) u_ex (
            .id_valid_i (id_valid_i),
            .rs_used_i  (id_rs_used_i[i]),
            .rs_addr_i  (id_rs_addr_i[i*ADDR_W +: ADDR_W]),
            .stg_valid_i(ex_valid_i),
            .rd_addr_i  (ex_rd_addr_i),
            .reg_write_i(ex_reg_write_i),
            .hit_o      (ex_hit[i])
        );
        rs_match_cell #(.ADDR_W(ADDR_W), .ZERO_REG_HW(ZERO_REG_HW)) u_mem (
            .id_valid_i (id_valid_i),
            .rs_used_i  (id_rs_used_i[i]),
            .rs_addr_i  (id_rs_addr_i[i*ADDR_W +: ADDR_W]),
            .stg_valid_i(mem_valid_i),
            .rd_addr_i  (mem_rd_addr_i),
            .reg_write_i(mem_reg_write_i),
            .hit_o      (mem_hit[i])
        );
    end

    assign lu_hit = |(ex_hit & {NUM_SRC{ex_is_load_i}});

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A single-bubble stall never enters STALL: the load reaches MEM next edge
    // and the same source then resolves as an ordinary MEM forward.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (lu_hit && LOAD_STALL_CYC > 1) begin
                    state_d = ST_STALL;
                    cnt_d   = CNT_INIT;
                end
            end
            ST_STALL: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall          = 1'b0;
        stall_active_o = 1'b0;
        unique case (state_q)
            ST_IDLE:  stall = lu_hit;
            ST_STALL: begin
                stall          = 1'b1;
                stall_active_o = 1'b1;
            end
            default:  stall = 1'b0;
        endcase
        if (reset_i) stall = 1'b0;
    end

    assign stall_o  = stall;
    assign bubble_o = stall;

    always_comb begin
        fwd_d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ex_hit[i])       fwd_d[i] = FWD_MEM;
            else if (mem_hit[i]) fwd_d[i] = FWD_WB;
            else                 fwd_d[i] = FWD_NONE;
        end
        if (stall) fwd_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) fwd_q <= '0;
        else         fwd_q <= fwd_d;
    end

    assign fwd_sel_o = fwd_q;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed-vector bench with a scoreboard: two DUT builds share the stimulus
// (A: 1-bubble load stall, x0 hard-wired; B: 3-bubble stall, x0 forwardable).
module tb_forward_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       idv;
    logic [9:0] rs;
    logic [1:0] used;
    logic       exv, exw, exld, memv, memw;
    logic [4:0] exrd, memrd;

    logic [3:0] fa, fb;
    logic       sta, stb, bua, bub, saa, sab;

    typedef struct {
        int         row;
        logic [2:0] m;
        logic       sta, stb, saa, sab;
        logic [3:0] fa, fb;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   row_n  = 0;

    localparam logic [2:0] M_ALL = 3'b111;
    localparam logic [2:0] M_SF  = 3'b011;
    localparam logic [2:0] M_S   = 3'b001;

    always #5 clk = ~clk;

    forward_hazard_unit #(.NUM_SRC(2), .ADDR_W(5), .LOAD_STALL_CYC(1), .ZERO_REG_HW(1'b1)) dut_a (
        .clk_i(clk), .reset_i(rst), .id_valid_i(idv), .id_rs_addr_i(rs), .id_rs_used_i(used),
        .ex_valid_i(exv), .ex_rd_addr_i(exrd), .ex_reg_write_i(exw), .ex_is_load_i(exld),
        .mem_valid_i(memv), .mem_rd_addr_i(memrd), .mem_reg_write_i(memw),
        .fwd_sel_o(fa), .stall_o(sta), .bubble_o(bua), .stall_active_o(saa)
    );

    forward_hazard_unit #(.NUM_SRC(2), .ADDR_W(5), .LOAD_STALL_CYC(3), .ZERO_REG_HW(1'b0)) dut_b (
        .clk_i(clk), .reset_i(rst), .id_valid_i(idv), .id_rs_addr_i(rs), .id_rs_used_i(used),
        .ex_valid_i(exv), .ex_rd_addr_i(exrd), .ex_reg_write_i(exw), .ex_is_load_i(exld),
        .mem_valid_i(memv), .mem_rd_addr_i(memrd), .mem_reg_write_i(memw),
        .fwd_sel_o(fb), .stall_o(stb), .bubble_o(bub), .stall_active_o(sab)
    );

    task automatic chk(input string name, input int row, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
        end
    endtask

    // Inputs: rst, id_valid, rs1, rs0, used, ex v/rd/we/load, mem v/rd/we.
    task automatic set_in(input logic r, input logic iv, input logic [4:0] r1, input logic [4:0] r0,
                          input logic [1:0] u, input logic ev, input logic [4:0] erd, input logic ew,
                          input logic el, input logic mv, input logic [4:0] mrd, input logic mw);
        @(posedge clk);
        #1;
        rst = r; idv = iv; rs = {r1, r0}; used = u;
        exv = ev; exrd = erd; exw = ew; exld = el;
        memv = mv; memrd = mrd; memw = mw;
    endtask

    task automatic idle(input logic r);
        set_in(r, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Expected at the following negedge: stall for current inputs, fwd/stall_active
    // as registered by the edge that opened this cycle.
    task automatic expect_o(input logic [2:0] m, input logic esa, input logic esb,
                            input logic [3:0] efa, input logic [3:0] efb,
                            input logic eaa, input logic eab);
        exp_t e;
        e.row = row_n; e.m = m;
        e.sta = esa; e.stb = esb; e.fa = efa; e.fb = efb; e.saa = eaa; e.sab = eab;
        sb.push_back(e);
        row_n++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.m[0]) begin
                    chk("stall_a",  e.row, {3'b0, sta}, {3'b0, e.sta});
                    chk("stall_b",  e.row, {3'b0, stb}, {3'b0, e.stb});
                    chk("bubble_a", e.row, {3'b0, bua}, {3'b0, e.sta});
                    chk("bubble_b", e.row, {3'b0, bub}, {3'b0, e.stb});
                end
                if (e.m[1]) begin
                    chk("fwd_a", e.row, fa, e.fa);
                    chk("fwd_b", e.row, fb, e.fb);
                end
                if (e.m[2]) begin
                    chk("stall_active_a", e.row, {3'b0, saa}, {3'b0, e.saa});
                    chk("stall_active_b", e.row, {3'b0, sab}, {3'b0, e.sab});
                end
            end
        end
    end

    initial begin : stim
        rst = 1; idv = 0; rs = '0; used = '0;
        exv = 0; exrd = '0; exw = 0; exld = 0; memv = 0; memrd = '0; memw = 0;

        idle(1);                                            expect_o(M_S,   0, 0, 4'h0, 4'h0, 0, 0);
        idle(0);                                            expect_o(M_ALL, 0, 0, 4'h0, 4'h0, 0, 0);
        // EX forward to src0, src1 untouched
        set_in(0, 1, 7, 5, 2'b11, 1, 5, 1, 0, 0, 0, 0);     expect_o(M_ALL, 0, 0, 4'h0, 4'h0, 0, 0);
        idle(0);                                            expect_o(M_ALL, 0, 0, 4'b0001, 4'b0001, 0, 0);
        // EX and MEM both hit -> EX wins; then EX not writing -> MEM
        set_in(0, 1, 0, 5, 2'b01, 1, 5, 1, 0, 1, 5, 1);     expect_o(M_ALL, 0, 0, 4'h0, 4'h0, 0, 0);
        set_in(0, 1, 0, 5, 2'b01, 1, 5, 0, 0, 1, 5, 1);     expect_o(M_ALL, 0, 0, 4'b0001, 4'b0001, 0, 0);
        idle(0);                                            expect_o(M_ALL, 0, 0, 4'b0010, 4'b0010, 0, 0);
        // rd=0 with both sources at x0: A suppresses, B forwards each source
        set_in(0, 1, 0, 0, 2'b11, 1, 0, 1, 0, 0, 0, 0);     expect_o(M_ALL, 0, 0, 4'h0, 4'h0, 0, 0);
        idle(0);                                            expect_o(M_ALL, 0, 0, 4'b0000, 4'b0101, 0, 0);
        // Load-use on src1: A stalls once then forwards from WB; B stalls 3 cycles
        set_in(0, 1, 9, 3, 2'b11, 1, 9, 1, 1, 0, 0, 0);     expect_o(M_ALL, 1, 1, 4'h0, 4'h0, 0, 0);
        set_in(0, 1, 9, 3, 2'b11, 0, 0, 0, 0, 1, 9, 1);     expect_o(M_ALL, 0, 1, 4'h0, 4'h0, 0, 1);
        set_in(0, 1, 9, 3, 2'b11, 0, 0, 0, 0, 1, 9, 1);     expect_o(M_ALL, 0, 1, 4'b1000, 4'h0, 0, 1);
        idle(0);                                            expect_o(M_ALL, 0, 0, 4'b1000, 4'h0, 0, 0);
        // Same load pattern with source unused -> nothing
        set_in(0, 1, 9, 3, 2'b00, 1, 9, 1, 1, 0, 0, 0);     expect_o(M_ALL, 0, 0, 4'h0, 4'h0, 0, 0);
        idle(0);                                            expect_o(M_ALL, 0, 0, 4'h0, 4'h0, 0, 0);
        // Invalid EX/MEM stages never hit
        set_in(0, 1, 0, 4, 2'b01, 0, 4, 1, 0, 0, 4, 1);     expect_o(M_ALL, 0, 0, 4'h0, 4'h0, 0, 0);
        idle(0);                                            expect_o(M_ALL, 0, 0, 4'h0, 4'h0, 0, 0);
        // Invalid decode slot never hits, even against a load
        set_in(0, 0, 0, 4, 2'b01, 1, 4, 1, 1, 0, 0, 0);     expect_o(M_ALL, 0, 0, 4'h0, 4'h0, 0, 0);
        idle(0);                                            expect_o(M_ALL, 0, 0, 4'h0, 4'h0, 0, 0);
        // Reset on B's second stall cycle
        set_in(0, 1, 0, 6, 2'b01, 1, 6, 1, 1, 0, 0, 0);     expect_o(M_ALL, 1, 1, 4'h0, 4'h0, 0, 0);
        idle(1);                                            expect_o(M_SF,  0, 0, 4'h0, 4'h0, 0, 0);
        idle(0);                                            expect_o(M_ALL, 0, 0, 4'h0, 4'h0, 0, 0);
        idle(0);                                            expect_o(M_ALL, 0, 0, 4'h0, 4'h0, 0, 0);

        for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/forward_hazard_unit.md
Name: forward_hazard_unit

Overview:
- Parametrised successor to the two-source ALU forwarding detector. Compares N decode-stage source register addresses against the destinations in the EX and MEM stages.
- Produces registered per-source forwarding selects for the EX stage.
- Adds write-enable/valid gating, x0 exclusion, younger-stage priority, and a load-use stall FSM with programmable stall length.
- Sits between the ID/EX pipeline register and the EX operand muxes.

Parameters:
- NUM_SRC, 2, number of source operands checked per instruction (1..4)
- ADDR_W, 5, register address width
- LOAD_STALL_CYC, 1, bubbles inserted on a load-use hit (1..7)
- ZERO_REG_HW, 1, when 1, a destination of address 0 never forwards and never stalls

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  decode slot holds a real instruction
- id_rs_addr  in  NUM_SRC*ADDR_W  source addresses; src i occupies bits [i*ADDR_W +: ADDR_W]
- id_rs_used  in  NUM_SRC  src i is actually read
- ex_valid  in  1  EX stage holds a real instruction
- ex_rd_addr  in  ADDR_W  EX destination
- ex_reg_write  in  1  EX instruction writes the register file
- ex_is_load  in  1  EX instruction is a load
- mem_valid  in  1  MEM stage valid
- mem_rd_addr  in  ADDR_W  MEM destination
- mem_reg_write  in  1  MEM writes the register file
- fwd_sel  out  2*NUM_SRC  per-source select, registered; 00 regfile, 01 from MEM, 10 from WB, 11 unused
- stall  out  1  hold PC and IF/ID (combinational, Mealy)
- bubble  out  1  zero control into ID/EX next edge (equals stall)
- stall_active  out  1  FSM is in STALL (registered)

Behaviour:
- Reset, synchronous, highest priority:
  - fwd_sel = 0, state = IDLE, cnt = 0, stall_active = 0.
  - stall and bubble forced to 0 while reset is high.
- Hit definitions, per src i, combinational:
  - ex_hit_i = id_valid & id_rs_used[i] & ex_valid & ex_reg_write & (ex_rd_addr == rs_i) & ~(ZERO_REG_HW & ex_rd_addr == 0).
  - mem_hit_i is the same expression using the mem_* inputs.
- Priority: ex_hit_i over mem_hit_i, because the younger value wins.
- Load-use condition:
  - lu_hit = OR over i of (ex_hit_i & ex_is_load).
- FSM state IDLE:
  - If lu_hit: stall = 1 this cycle.
  - If LOAD_STALL_CYC == 1: remain in IDLE; the load has advanced to MEM on the next edge, so the hit re-evaluates as a MEM hit.
  - Else: go to STALL with cnt = LOAD_STALL_CYC-1.
- FSM state STALL:
  - stall = 1 and stall_active = 1.
  - cnt decrements each cycle; at cnt == 1, return to IDLE.
  - New inputs are ignored while in STALL; the condition is re-evaluated in IDLE.
- fwd_sel register, updated each posedge:
  - When not stalling: fwd_sel[i] = ex_hit_i ? 01 : mem_hit_i ? 10 : 00, latency one cycle (ID compare -> EX use).
  - When stall = 1: fwd_sel is loaded with 0, because the bubble entering EX reads nothing.
- Boundary cases:
  - Identical rs addresses across sources: each source gets an independent select.
  - ex and mem both hit: select is 01.
  - id_rs_used[i] = 0: select is 00 regardless of address.
  - Invalid stages never hit.
  - Reset in STALL: IDLE next edge, stall deasserts immediately.

Decomposition:
- Shared package (hazard_pkg) holds the FWD_NONE/FWD_MEM/FWD_WB 2-bit encodings and the IDLE/STALL state encoding.
- One natural sub-module, rs_match_cell: single-source compare against one stage with gating and x0 exclusion. It is instanced 2*NUM_SRC times via generate.

Test Plan:
- Reset mid-STALL (LOAD_STALL_CYC=3, reset on 2nd stall cycle) -> stall=0 during reset; fwd_sel=0, stall_active=0 after edge.
- EX rd=5 reg_write=1, ID rs1=5 rs2=7 used=11 -> next cycle fwd_sel={00,01}; stall=0.
- EX rd=5 and MEM rd=5 both writing, rs1=5 -> fwd_sel[1:0]=01 (EX priority); with ex_reg_write=0 -> 10.
- rd=0 writing, rs1=0 with ZERO_REG_HW=1 -> fwd_sel=0; with ZERO_REG_HW=0 -> 01.
- Load in EX rd=9, rs2=9, LOAD_STALL_CYC=1 -> stall=1 for exactly 1 cycle, fwd_sel=0; next cycle load in MEM -> fwd_sel[3:2]=10.
- LOAD_STALL_CYC=3, load-use hit -> stall high exactly 3 consecutive cycles, stall_active high cycles 2-3; id_rs_used=0 on the same pattern -> no stall.
